sign_mag_accum: RTL and testbench
=================================

SIGN_MAG_ACCUM -- requirements
Module: sign_mag_accum

Interface
REQ-001 Parameter W, default 5: total operand width; bit W-1 is the sign (1 = negative) and bits W-2:0 are the magnitude; W SHALL be at least 3.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand transaction offered.
REQ-005 in_ready  output  1  block can accept a transaction this cycle.
REQ-006 a  input  W  sign-magnitude operand x; used only when acc_mode=0.
REQ-007 b  input  W  sign-magnitude operand y.
REQ-008 op_sub  input  1  1 = subtract: y is b with its sign bit inverted.
REQ-009 acc_mode  input  1  1 = x is taken from the internal accumulator instead of a.
REQ-010 acc_clr  input  1  sampled only on accept; clears the accumulator and the sticky overflow flag.
REQ-011 out_valid  output  1  result register holds an unconsumed result.
REQ-012 out_ready  input  1  downstream consumes the result.
REQ-013 sum  output  W  sign-magnitude result.
REQ-014 ovf  output  1  the result in sum saturated.
REQ-015 ovf_sticky  output  1  OR of ovf over all accepted transactions since the last reset or accepted acc_clr.

Function
REQ-016 Accept: a transaction is accepted when in_valid and in_ready are both high on a rising edge.
REQ-017 Ready rule: in_ready SHALL equal (!out_valid || out_ready), so the block accepts a new transaction in the same cycle the old result is consumed.
REQ-018 Latency: sum and ovf for an accepted transaction SHALL appear on the next rising edge, with out_valid=1.
REQ-019 Result hold: while out_valid=1 and out_ready=0, sum, ovf and out_valid SHALL hold stable.
REQ-020 Clear out_valid: out_valid SHALL clear on a consume (out_valid && out_ready) that coincides with no new accept.
REQ-021 Operand x selection:
  - acc_mode=0: x = a.
  - acc_mode=1 and acc_clr=1: x = +0.
  - acc_mode=1 and acc_clr=0: x = the accumulator value.
REQ-022 Negative zero: any operand with zero magnitude SHALL be treated as +0, and sum SHALL never be driven as negative zero (sign=1, magnitude=0).
REQ-023 Equal signs: the magnitude is |x|+|y| and the sign is the common sign.
REQ-024 Saturation: if |x|+|y| exceeds 2^(W-1)-1, the magnitude SHALL saturate to 2^(W-1)-1 with the common sign, and ovf=1.
REQ-025 Differing signs: the magnitude is larger minus smaller, the sign is that of the larger-magnitude operand, equal magnitudes give +0, and ovf=0.
REQ-026 Accumulator update on accept:
  - acc_mode=1: the accumulator SHALL load the (saturated) result.
  - acc_mode=0 with acc_clr=1: the accumulator SHALL load +0.
  - acc_mode=0 with acc_clr=0: the accumulator is unchanged.
REQ-027 Sticky flag update on accept:
  - acc_clr=1: ovf_sticky SHALL load the current result's ovf.
  - acc_clr=0: ovf_sticky SHALL load ovf_sticky | ovf.
REQ-028 Non-accepted cycles: acc_clr, op_sub, acc_mode, a and b SHALL have no effect when no transaction is accepted.
REQ-029 Combinational path: no combinational path SHALL exist from in_valid, a or b to any output; in_ready depends only on out_valid and out_ready.

Reset
REQ-030 While reset is high, regardless of clk:
  - out_valid=0, sum=0, ovf=0, ovf_sticky=0;
  - accumulator=+0;
  - in_ready=1 after out_valid clears.
REQ-031 Reset mid-operation: reset asserted while a result is pending or stalled SHALL discard that result, and the first accept after reset deasserts SHALL behave as from power-up.

Verification (W=5)
REQ-032 Signed add: acc_mode=0, op_sub=0, one transaction each, out_ready=1:
  - a=01000, b=11000 -> sum=00000, ovf=0.
  - a=10101, b=01100 -> sum=00111.
  - a=01001, b=11111 -> sum=10110.
REQ-033 Saturation and sticky: a=01110, b=00011 -> sum=01111, ovf=1, ovf_sticky=1; next a=10110, b=00010 -> sum=10100, ovf=0, ovf_sticky still 1.
REQ-034 Negative zero: a=10000, b=10000 -> sum=00000; a=00011 with b=00011 and op_sub=1 -> sum=00000.
REQ-035 Accumulate sequence, acc_mode=1:
  - acc_clr=1, b=00101 -> sum=00101, ovf_sticky=0.
  - then b=11001 -> sum=10100.
  - then op_sub=1, b=00110 -> sum=11010.
  - then op_sub=1, b=01111 -> sum=11111, ovf=1.
REQ-036 Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1: sum stays stable, in_ready=0, no second accept.
  - Raising out_ready gives one consume and one accept in the same cycle, and out_valid stays 1.
REQ-037 Reset: assert reset asynchronously (between clock edges) while a stalled result is pending -> out_valid, sum, ovf_sticky go to 0 immediately; a later acc_mode=1 transaction with acc_clr=0 and b=00001 gives sum=00001.

Source files
------------

// File: rtl/sign_mag_accum.sv
// Sign-magnitude add/subtract with saturation and a running accumulator; result registered, 1-cycle latency.
// Backpressure: in_ready = !out_valid || out_ready; result, ovf and out_valid hold while stalled.
module sign_mag_accum #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op_sub,
  input  logic         acc_mode,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         ovf,
  output logic         ovf_sticky
);

  localparam int M = W - 1;
  localparam logic [M-1:0] MAG_MAX = '1;

  logic [W-1:0] acc;
  logic [W-1:0] x_raw;
  logic [W-1:0] y_raw;
  logic         xs;
  logic         ys;
  logic [M-1:0] xm;
  logic [M-1:0] ym;
  logic [M:0]   mag_add;
  logic [M-1:0] res_mag;
  logic         res_sign;
  logic         res_ovf;
  logic         accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    x_raw = a;
    if (acc_mode) begin
      x_raw = acc_clr ? '0 : acc;
    end
    y_raw = {b[W-1] ^ op_sub, b[M-1:0]};

    xm = x_raw[M-1:0];
    ym = y_raw[M-1:0];
    // A zero magnitude always counts as +0, whatever its sign bit says.
    xs = x_raw[W-1] & (|xm);
    ys = y_raw[W-1] & (|ym);

    mag_add  = {1'b0, xm} + {1'b0, ym};
    res_mag  = '0;
    res_sign = 1'b0;
    res_ovf  = 1'b0;

    if (xs == ys) begin
      res_sign = xs;
      // Magnitude max is all ones, so any carry out means saturation.
      if (mag_add[M]) begin
        res_mag = MAG_MAX;
        res_ovf = 1'b1;
      end else begin
        res_mag = mag_add[M-1:0];
      end
    end else if (xm > ym) begin
      res_mag  = xm - ym;
      res_sign = xs;
    end else if (ym > xm) begin
      res_mag  = ym - xm;
      res_sign = ys;
    end

    if (res_mag == '0) begin
      res_sign = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      sum        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      acc        <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      sum        <= {res_sign, res_mag};
      ovf        <= res_ovf;
      ovf_sticky <= acc_clr ? res_ovf : (ovf_sticky | res_ovf);
      if (acc_mode) begin
        acc <= {res_sign, res_mag};
      end else if (acc_clr) begin
        acc <= '0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed-vector bench for sign_mag_accum at W=5.
module tb_sign_mag_accum;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       op_sub;
  logic       acc_mode;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum;
  logic       ovf;
  logic       ovf_sticky;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic       sub;
    logic       mode;
    logic       clr;
    logic [4:0] exp_sum;
    logic       exp_ovf;
    logic       exp_sticky;
  } vec_t;

  vec_t vecs[15];

  sign_mag_accum #(.W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op_sub     (op_sub),
    .acc_mode   (acc_mode),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a        = v.a;
    b        = v.b;
    op_sub   = v.sub;
    acc_mode = v.mode;
    acc_clr  = v.clr;
  endtask

  // One accepted transaction with out_ready=1; checks the registered result.
  task automatic run_vec(input int idx, input vec_t v);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid", idx), out_valid, 1'b1);
    chk($sformatf("v%0d_sum", idx), sum, v.exp_sum);
    chk($sformatf("v%0d_ovf", idx), ovf, v.exp_ovf);
    chk($sformatf("v%0d_sticky", idx), ovf_sticky, v.exp_sticky);
  endtask

  initial begin
    vec_t t;
    //            a         b        sub   mode  clr   sum       ovf   sticky
    vecs[0]  = '{5'b01000, 5'b11000, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{5'b10101, 5'b01100, 1'b0, 1'b0, 1'b0, 5'b00111, 1'b0, 1'b0};
    vecs[2]  = '{5'b01001, 5'b11111, 1'b0, 1'b0, 1'b0, 5'b10110, 1'b0, 1'b0};
    vecs[3]  = '{5'b01110, 5'b00011, 1'b0, 1'b0, 1'b0, 5'b01111, 1'b1, 1'b1};
    vecs[4]  = '{5'b10110, 5'b00010, 1'b0, 1'b0, 1'b0, 5'b10100, 1'b0, 1'b1};
    vecs[5]  = '{5'b10000, 5'b10000, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1};
    vecs[6]  = '{5'b00011, 5'b00011, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1};
    vecs[7]  = '{5'b11111, 5'b00101, 1'b0, 1'b1, 1'b1, 5'b00101, 1'b0, 1'b0};
    vecs[8]  = '{5'b01111, 5'b11001, 1'b0, 1'b1, 1'b0, 5'b10100, 1'b0, 1'b0};
    vecs[9]  = '{5'b00000, 5'b00110, 1'b1, 1'b1, 1'b0, 5'b11010, 1'b0, 1'b0};
    vecs[10] = '{5'b00000, 5'b01111, 1'b1, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b1};
    vecs[11] = '{5'b00001, 5'b00001, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0, 1'b0};
    vecs[12] = '{5'b01111, 5'b00010, 1'b0, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b0};
    vecs[13] = '{5'b10111, 5'b00111, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0};
    vecs[14] = '{5'b10000, 5'b00101, 1'b0, 1'b0, 1'b0, 5'b00101, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    acc_mode  = 1'b0;
    acc_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 5'b00000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_vec(i, vecs[i]);
    end

    // Control inputs toggled without an accept must not touch the accumulator.
    acc_mode = 1'b1;
    acc_clr  = 1'b1;
    b        = 5'b11111;
    @(posedge clk);
    #1;
    chk("idle_valid_clear", out_valid, 1'b0);
    @(posedge clk);
    #1;
    t = '{5'b00000, 5'b00001, 1'b0, 1'b1, 1'b0, 5'b00011, 1'b0, 1'b0};
    run_vec(100, t);

    // Backpressure: A accepted, B offered while the output is stalled.
    out_ready = 1'b0;
    t = '{5'b00001, 5'b00010, 1'b0, 1'b0, 1'b0, 5'b00011, 1'b0, 1'b0};
    drive(t);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 5'b00100;
    b = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d_sum", i), sum, 5'b00011);
      chk($sformatf("bp%0d_ready", i), in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_swap_valid", out_valid, 1'b1);
    chk("bp_swap_sum", sum, 5'b00101);
    @(posedge clk);
    #1;
    chk("bp_drain_valid", out_valid, 1'b0);

    // Asynchronous reset while a saturated result is stalled.
    out_ready = 1'b0;
    t = '{5'b01111, 5'b00001, 1'b0, 1'b0, 1'b0, 5'b01111, 1'b1, 1'b1};
    drive(t);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_sticky", ovf_sticky, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_sum", sum, 5'b00000);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_sticky", ovf_sticky, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    t = '{5'b01010, 5'b00001, 1'b0, 1'b1, 1'b0, 5'b00001, 1'b0, 1'b0};
    run_vec(200, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
